// File: rtl/alu_div_if.sv
// Operand/result bundle between the execute-stage control unit and the divider.
// The control unit is the master; the divider is the slave.
interface alu_div_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] d_in1;
  logic [WIDTH-1:0] d_in2;
  logic             ready;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, is_signed, d_in1, d_in2,
    input  ready, busy, valid, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, d_in1, d_in2,
    output ready, busy, valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, MSB first,
// on operand magnitudes, with signs applied when the result is registered.
//
// state | meaning
// IDLE  | ready; accepts start, resolves divide-by-zero / overflow directly
// CALC  | one restoring step per cycle, counter runs WIDTH down to 0
// FIN   | sign fix-up, results registered, valid pulsed
module alu_div #(
  parameter  int WIDTH = 24,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     rst,
  alu_div_if.slave dif
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [CNT_W-1:0] cnt;
  logic             qneg, rneg;
  logic             spc, spc_dz;
  logic             valid_q, div_zero_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic             accept, a_neg, b_neg, dz_in, ovf_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;

  assign accept = dif.start && (state == IDLE);
  assign a_neg  = dif.is_signed & dif.d_in1[WIDTH-1];
  assign b_neg  = dif.is_signed & dif.d_in2[WIDTH-1];
  assign a_mag  = a_neg ? -dif.d_in1 : dif.d_in1;
  assign b_mag  = b_neg ? -dif.d_in2 : dif.d_in2;
  assign dz_in  = (dif.d_in2 == '0);
  assign ovf_in = dif.is_signed && (dif.d_in1 == MIN_NEG) && (&dif.d_in2);

  // rem < dvs always holds, so rem_sh < 2*dvs and bit WIDTH of the
  // WIDTH+1-bit difference is exactly the borrow out.
  assign rem_sh = {rem, dvd[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign q_bit  = ~diff[WIDTH];
  assign rem_nx = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !dz_in && !ovf_in) state_nx = CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      spc         <= 1'b0;
      spc_dz      <= 1'b0;
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      spc     <= 1'b0;
      // Special-case results were staged in dvd/rem at the capture edge.
      if (spc) begin
        quotient_q  <= dvd;
        remainder_q <= rem;
        div_zero_q  <= spc_dz;
        valid_q     <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (dz_in) begin
              dvd    <= '1;
              rem    <= dif.d_in1;
              spc    <= 1'b1;
              spc_dz <= 1'b1;
            end else if (ovf_in) begin
              dvd    <= MIN_NEG;
              rem    <= '0;
              spc    <= 1'b1;
              spc_dz <= 1'b0;
            end else begin
              dvd  <= a_mag;
              dvs  <= b_mag;
              rem  <= '0;
              qneg <= a_neg ^ b_neg;
              rneg <= a_neg;
              cnt  <= CNT_W'(WIDTH);
            end
          end
        end
        CALC: begin
          dvd <= {dvd[WIDTH-2:0], q_bit};
          rem <= rem_nx;
          cnt <= cnt - CNT_W'(1);
        end
        FIN: begin
          quotient_q  <= qneg ? -dvd : dvd;
          remainder_q <= rneg ? -rem : rem;
          div_zero_q  <= 1'b0;
          valid_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dif.ready     = (state == IDLE);
  assign dif.busy      = (state != IDLE);
  assign dif.valid     = valid_q;
  assign dif.quotient  = quotient_q;
  assign dif.remainder = remainder_q;
  assign dif.div_zero  = div_zero_q;
endmodule

// File: tb/tb_alu_div.sv
// Directed table, control-sequence corner cases and a random regression
// against a reference built on the simulator's own / and % operators.
module tb_alu_div;
  localparam int W = 24;

  typedef struct {
    string       nm;
    logic        s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_div_if #(.WIDTH(W)) dif ();
  alu_div #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .dif(dif));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    int sa, sb;
    dz  = 1'b0;
    lat = W + 1;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1; lat = 1;
    end else if (s && a == 24'h800000 && b == 24'hFFFFFF) begin
      q = a; r = '0; lat = 1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Returns at the negedge where valid is seen (or after the cycle budget).
  task automatic wait_result(input int lat0, output int lat, output logic b1);
    bit done = 0;
    lat = lat0;
    b1  = 1'b0;
    while (!done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == lat0 + 1) b1 = dif.busy;
      if (dif.valid) done = 1;
    end
  endtask

  // Caller is at a negedge when sync=0.
  task automatic do_op(input string nm, input bit sync, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input int elat);
    int   lat;
    logic b1;
    if (sync) @(negedge clk);
    dif.start     = 1'b1;
    dif.is_signed = s;
    dif.d_in1     = a;
    dif.d_in2     = b;
    @(posedge clk);
    #1 dif.start = 1'b0;
    wait_result(0, lat, b1);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " busy"}, b1, (elat > 1));
    chk({nm, " quotient"}, dif.quotient, eq);
    chk({nm, " remainder"}, dif.remainder, er);
    chk({nm, " div_zero"}, dif.div_zero, edz);
  endtask

  vec_t vt[$];

  initial begin
    int   lat, nval;
    logic b1;
    logic [W-1:0] ra, rb, mq, mr;
    logic mdz, rs;
    int   mlat;

    vt.push_back('{"u100/7",       0, 24'd100,    24'd7,      24'd14,     24'd2,      0, 25});
    vt.push_back('{"s-100/7",      1, 24'hFFFF9C, 24'd7,      24'hFFFFF2, 24'hFFFFFE, 0, 25});
    vt.push_back('{"s100/-7",      1, 24'd100,    24'hFFFFF9, 24'hFFFFF2, 24'd2,      0, 25});
    vt.push_back('{"s-100/-7",     1, 24'hFFFF9C, 24'hFFFFF9, 24'd14,     24'hFFFFFE, 0, 25});
    vt.push_back('{"uFFFFFF/2",    0, 24'hFFFFFF, 24'd2,      24'h7FFFFF, 24'd1,      0, 25});
    vt.push_back('{"sFFFFFF/2",    1, 24'hFFFFFF, 24'd2,      24'd0,      24'hFFFFFF, 0, 25});
    vt.push_back('{"u_div0",       0, 24'h123456, 24'd0,      24'hFFFFFF, 24'h123456, 1, 1});
    vt.push_back('{"u9/3",         0, 24'd9,      24'd3,      24'd3,      24'd0,      0, 25});
    vt.push_back('{"s_ovf",        1, 24'h800000, 24'hFFFFFF, 24'h800000, 24'd0,      0, 1});
    vt.push_back('{"s_div0",       1, 24'h123456, 24'd0,      24'hFFFFFF, 24'h123456, 1, 1});
    vt.push_back('{"u800000/max",  0, 24'h800000, 24'hFFFFFF, 24'd0,      24'h800000, 0, 25});
    vt.push_back('{"u5/9",         0, 24'd5,      24'd9,      24'd0,      24'd5,      0, 25});
    vt.push_back('{"uFFFFFF/1",    0, 24'hFFFFFF, 24'd1,      24'hFFFFFF, 24'd0,      0, 25});
    vt.push_back('{"s800000/1",    1, 24'h800000, 24'd1,      24'h800000, 24'd0,      0, 25});

    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.d_in1     = '0;
    dif.d_in2     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ready", dif.ready, 1);
    chk("reset busy", dif.busy, 0);
    chk("reset valid", dif.valid, 0);
    chk("reset quotient", dif.quotient, 0);
    chk("reset remainder", dif.remainder, 0);
    chk("reset div_zero", dif.div_zero, 0);

    foreach (vt[i])
      do_op(vt[i].nm, 1, vt[i].s, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].lat);

    // start while busy is ignored and operand changes have no effect
    @(negedge clk);
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.d_in1 = 24'd50; dif.d_in2 = 24'd5;
    @(posedge clk);
    #1 dif.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    dif.start = 1'b1; dif.d_in1 = 24'd9; dif.d_in2 = 24'd2;
    @(posedge clk);
    #1 dif.start = 1'b0;
    wait_result(10, lat, b1);
    chk("ignore latency", lat, 25);
    chk("ignore quotient", dif.quotient, 10);
    chk("ignore remainder", dif.remainder, 0);
    chk("valid-cycle ready", dif.ready, 1);

    // back-to-back start in the valid cycle
    do_op("b2b81/9", 0, 0, 24'd81, 24'd9, 24'd9, 24'd0, 0, 25);
    @(negedge clk);
    chk("valid one cycle", dif.valid, 0);

    // reset mid-division aborts without a valid pulse
    dif.start = 1'b1; dif.d_in1 = 24'd7; dif.d_in2 = 24'd1;
    @(posedge clk);
    #1 dif.start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort valid", dif.valid, 0);
    chk("abort quotient", dif.quotient, 0);
    chk("abort remainder", dif.remainder, 0);
    chk("abort ready", dif.ready, 1);
    chk("abort busy", dif.busy, 0);
    @(negedge clk);
    rst  = 1'b0;
    nval = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.valid) nval++;
    end
    chk("abort no valid", nval, 0);

    for (int k = 0; k < 500; k++) begin
      int mode;
      mode = $urandom_range(0, 9);
      rs   = 1'($urandom_range(0, 1));
      ra   = W'($urandom);
      if (mode == 0)      rb = '0;
      else if (mode < 4)  rb = W'($urandom_range(1, 15));
      else if (mode == 4) rb = 24'hFFFFFF;
      else                rb = W'($urandom);
      if (mode == 4 && k % 2 == 0) ra = 24'h800000;
      model(rs, ra, rb, mq, mr, mdz, mlat);
      do_op($sformatf("rnd%0d", k), 1, rs, ra, rb, mq, mr, mdz, mlat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_div.md
Name: alu_div

Overview:
Iterative radix-2 restoring divider that computes quotient and remainder for the core. It performs the inverse of the ALU's single-cycle multiply path. It sits beside the combinational ALU in the execute stage. The control unit issues an operand pair with a start pulse, stalls while the divider is busy, and captures results on a one-cycle valid pulse.

Parameters:
WIDTH, 24, operand/result width in bits (core word width)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  core clock, rising-edge
rst  input  1  reset; one clock, reset asynchronous and active-high
start  input  1  request; sampled only when ready=1
is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
d_in1  input  WIDTH  dividend; sampled with start
d_in2  input  WIDTH  divisor; sampled with start
ready  output  1  idle, able to accept start
busy  output  1  division in progress (equals ~ready)
valid  output  1  one-cycle pulse: quotient/remainder/div_zero are new
quotient  output  WIDTH  result quotient, held until next accepted start completes
remainder  output  WIDTH  result remainder, held likewise
div_zero  output  1  last completed op had divisor == 0, held likewise

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, quotient=0, remainder=0, div_zero=0, valid=0; ready=1, busy=0. Reset mid-division aborts with no valid pulse.
- FSM states:
  - IDLE -> CALC on start&ready with divisor!=0 and no signed overflow.
  - IDLE -> IDLE with valid pulse next cycle for the divide-by-zero and overflow special cases.
  - CALC -> CALC while counter!=0.
  - CALC -> FIN when counter reaches 0.
  - FIN -> IDLE, registering results and pulsing valid.
- Capture edge:
  - Latch the operand magnitudes: abs() if is_signed and MSB set, else raw.
  - Latch the quotient sign (msb1^msb2 when signed) and the remainder sign (msb1 when signed).
  - counter=WIDTH.
- CALC, one quotient bit per cycle, MSB first:
  - Form rem' = {rem, dividend_msb}, then shift the dividend left.
  - If rem' >= divisor: rem = rem' - divisor and q bit = 1; else rem = rem' and q bit = 0.
  - Use a WIDTH+1-bit subtraction; the borrow out decides the bit.
- FIN: negate q if the quotient sign is set; negate rem if the remainder sign is set. Truncation is toward zero, and the remainder takes the dividend's sign.
- Latency: start sampled at edge E0; valid is high during the cycle after edge E0+WIDTH+1. For WIDTH=24 that is 25 edges after the start edge.
- Divide by zero (d_in2==0): at the edge after capture, quotient = all ones, remainder = d_in1, div_zero=1, valid=1. Latency is 1 edge and is independent of is_signed.
- Signed overflow (is_signed, d_in1 = 1<<(WIDTH-1), d_in2 = all ones): quotient = d_in1, remainder = 0, div_zero=0, latency 1 edge.
- Every non-zero-divisor completion clears div_zero.
- valid is high for exactly one cycle; ready is also 1 in that cycle. A start in the valid cycle is accepted back-to-back.
- start while busy is ignored and not queued. Operand changes while busy have no effect.
- quotient/remainder/div_zero change only on the valid-producing edge; they never show intermediate values.

Test Plan:
- Unsigned, d_in1=100, d_in2=7, start for 1 cycle -> valid 25 edges later, quotient=14, remainder=2, div_zero=0, busy high during the wait.
- Signed, d_in1=0xFFFF9C (-100), d_in2=7 -> quotient=0xFFFFF2 (-14), remainder=0xFFFFFE (-2). Also 100/-7 -> 0xFFFFF2 r 2.
- Unsigned vs signed, d_in1=0xFFFFFF, d_in2=2 -> unsigned gives 0x7FFFFF r 1; signed gives 0 r 0xFFFFFF.
- d_in1=0x123456, d_in2=0 -> valid 1 edge later, quotient=0xFFFFFF, remainder=0x123456, div_zero=1. A following 9/3 gives 3 r 0 with div_zero=0.
- Signed 0x800000 / 0xFFFFFF -> valid 1 edge later, quotient=0x800000, remainder=0.
- Control sequence:
  - Start 50/5.
  - Pulse start with 9/2 at cycle 10 -> ignored, and 10 r 0 is reported.
  - Assert rst at cycle 12 of a new op -> no valid, outputs 0, ready=1.
  - Start in the valid cycle -> accepted.
- Random regression: 500 random pairs, both signednesses -> results match the reference model.
